// File: rtl/e203_exu_brchslv_pkg.sv
// Shared definitions for the commit-side branch resolver.
package e203_exu_brchslv_pkg;

  localparam int E203_PC_SIZE = 32;

  localparam logic [0:0] BRSLV_IDLE = 1'b0;
  localparam logic [0:0] BRSLV_REQ  = 1'b1;

  // Byte length of the committing instruction, used for the fall-through PC.
  function automatic logic [2:0] instr_len(input logic rv32);
    return rv32 ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/e203_sat_cnt.sv
// Saturating event counter with synchronous clear.
module e203_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/e203_exu_brchslv.sv
// Commit-side branch resolver: detects mispredicts and fence.i, requests an
// IFU flush with the corrected PC, and counts retired branches/mispredicts.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   BRSLV_IDLE | accepting commits, no flush outstanding
//   BRSLV_REQ  | flush_req raised to IFU, commit stalled until flush_ack
module e203_exu_brchslv
  import e203_exu_brchslv_pkg::*;
#(
  parameter int PC_SIZE = E203_PC_SIZE,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic               cmt_i_rv32,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_fencei,
  input  logic               cmt_i_bjp_prdt,
  input  logic               cmt_i_bjp_rslv,
  input  logic [PC_SIZE-1:0] cmt_i_bjp_tgt,
  output logic               flush_req,
  input  logic               flush_ack,
  output logic [PC_SIZE-1:0] flush_pc,
  output logic               cmt_ena,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   bjp_cnt,
  output logic [CNT_W-1:0]   mis_cnt
);

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic               cmt_acc;
  logic               mispred;
  logic               need_flush;
  logic [PC_SIZE-1:0] seq_pc;
  logic [PC_SIZE-1:0] nxt_pc;

  // A bjp that is also tagged fence.i is treated purely as a branch.
  assign mispred    = cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);
  assign need_flush = mispred | (cmt_i_fencei & ~cmt_i_bjp);

  // Fall-through PC wraps modulo 2^PC_SIZE; the carry is intentionally lost.
  assign seq_pc = cmt_i_pc + PC_SIZE'(instr_len(cmt_i_rv32));
  assign nxt_pc = (cmt_i_bjp & cmt_i_bjp_rslv) ? cmt_i_bjp_tgt : seq_pc;

  assign cmt_i_ready = (state == BRSLV_IDLE);
  assign cmt_acc     = cmt_i_valid & cmt_i_ready;
  assign cmt_ena     = cmt_acc;
  assign flush_req   = (state == BRSLV_REQ);

  // Next-state: enter REQ on a flushing commit, leave on IFU ack.
  always_comb begin
    state_nxt = state;
    case (state)
      BRSLV_IDLE: if (cmt_acc && need_flush) state_nxt = BRSLV_REQ;
      BRSLV_REQ:  if (flush_ack)             state_nxt = BRSLV_IDLE;
      default:                               state_nxt = BRSLV_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BRSLV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Restart PC is captured only at a flushing accept, so it stays put in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pc <= '0;
    end else if (cmt_acc && need_flush) begin
      flush_pc <= nxt_pc;
    end
  end

  e203_sat_cnt #(.CNT_W(CNT_W)) u_bjp_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cmt_acc & cmt_i_bjp),
    .clr (cnt_clr),
    .cnt (bjp_cnt)
  );

  e203_sat_cnt #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cmt_acc & mispred),
    .clr (cnt_clr),
    .cnt (mis_cnt)
  );

endmodule

// File: tb/tb_e203_exu_brchslv.sv
// Scoreboard bench for the commit-side branch resolver.
module tb_e203_exu_brchslv;

  localparam int PW = 32;
  localparam int CW = 4;

  typedef struct {
    logic          flush;
    logic [PW-1:0] fpc;
    logic [CW-1:0] bjp;
    logic [CW-1:0] mis;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmt_i_valid = 1'b0;
  logic          cmt_i_ready;
  logic [PW-1:0] cmt_i_pc = '0;
  logic          cmt_i_rv32 = 1'b0;
  logic          cmt_i_bjp = 1'b0;
  logic          cmt_i_fencei = 1'b0;
  logic          cmt_i_bjp_prdt = 1'b0;
  logic          cmt_i_bjp_rslv = 1'b0;
  logic [PW-1:0] cmt_i_bjp_tgt = '0;
  logic          flush_req;
  logic          flush_ack = 1'b0;
  logic [PW-1:0] flush_pc;
  logic          cmt_ena;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] bjp_cnt;
  logic [CW-1:0] mis_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];
  int unsigned m_bjp = 0;
  int unsigned m_mis = 0;
  logic [PW-1:0] held_pc;

  e203_exu_brchslv #(.PC_SIZE(PW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmt_i_valid    (cmt_i_valid),
    .cmt_i_ready    (cmt_i_ready),
    .cmt_i_pc       (cmt_i_pc),
    .cmt_i_rv32     (cmt_i_rv32),
    .cmt_i_bjp      (cmt_i_bjp),
    .cmt_i_fencei   (cmt_i_fencei),
    .cmt_i_bjp_prdt (cmt_i_bjp_prdt),
    .cmt_i_bjp_rslv (cmt_i_bjp_rslv),
    .cmt_i_bjp_tgt  (cmt_i_bjp_tgt),
    .flush_req      (flush_req),
    .flush_ack      (flush_ack),
    .flush_pc       (flush_pc),
    .cmt_ena        (cmt_ena),
    .cnt_clr        (cnt_clr),
    .bjp_cnt        (bjp_cnt),
    .mis_cnt        (mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one commit, waits (bounded) for acceptance and queues the
  // hand-computed response. Called #1 after a rising edge; returns likewise.
  task automatic do_commit(input logic [PW-1:0] pc, input logic rv32, input logic bjp,
                           input logic fencei, input logic prdt, input logic rslv,
                           input logic [PW-1:0] tgt, input logic clr,
                           input logic exp_flush, input logic [PW-1:0] exp_fpc);
    exp_t e;
    int guard = 0;
    cmt_i_valid = 1'b1; cmt_i_pc = pc; cmt_i_rv32 = rv32; cmt_i_bjp = bjp;
    cmt_i_fencei = fencei; cmt_i_bjp_prdt = prdt; cmt_i_bjp_rslv = rslv;
    cmt_i_bjp_tgt = tgt; cnt_clr = clr;
    while (!cmt_i_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("commit_accept_timeout", {31'd0, cmt_i_ready}, 32'd1);
    if (cmt_i_ready) begin
      if (clr) begin
        m_bjp = 0; m_mis = 0;
      end else begin
        if (bjp && m_bjp < 15) m_bjp++;
        if (bjp && exp_flush && m_mis < 15) m_mis++;
      end
      e.flush = exp_flush; e.fpc = exp_fpc;
      e.bjp = CW'(m_bjp); e.mis = CW'(m_mis);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmt_i_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic ack_flush();
    flush_ack = 1'b1;
    @(posedge clk); #1;
    flush_ack = 1'b0;
  endtask

  // Monitor: a response is checked one cycle after the cmt_ena that produced it.
  initial begin : monitor
    exp_t pend;
    bit   have_pend;
    have_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_pend = 1'b0;
        continue;
      end
      if (have_pend) begin
        check("flush_req_after_cmt", {31'd0, flush_req}, {31'd0, pend.flush});
        if (pend.flush) check("flush_pc", flush_pc, pend.fpc);
        check("bjp_cnt", {28'd0, bjp_cnt}, {28'd0, pend.bjp});
        check("mis_cnt", {28'd0, mis_cnt}, {28'd0, pend.mis});
        have_pend = 1'b0;
      end
      if (cmt_ena) begin
        check("cmt_ena_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          pend = exp_q.pop_front();
          have_pend = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #2;
    check("rst_flush_req", {31'd0, flush_req}, 32'd0);
    check("rst_flush_pc", flush_pc, 32'd0);
    check("rst_bjp_cnt", {28'd0, bjp_cnt}, 32'd0);
    check("rst_mis_cnt", {28'd0, mis_cnt}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, cmt_i_ready}, 32'd1);
    check("idle_cmt_ena", {31'd0, cmt_ena}, 32'd0);

    // Correct taken prediction: no flush.
    do_commit(32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    // Non-branch with stray prdt/rslv: ignored, no flush.
    do_commit(32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Predicted taken, resolved not taken, ack held off for 3 cycles.
    do_commit(32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h900, 1'b0, 1'b1, 32'h204);
    held_pc = flush_pc;
    for (int i = 0; i < 3; i++) begin
      check("req_ready_low", {31'd0, cmt_i_ready}, 32'd0);
      check("req_flush_held", {31'd0, flush_req}, 32'd1);
      check("req_pc_stable", flush_pc, 32'h204);
      check("req_cmt_ena_low", {31'd0, cmt_ena}, 32'd0);
      @(posedge clk); #1;
    end
    ack_flush();
    check("ack_flush_drop", {31'd0, flush_req}, 32'd0);
    check("ack_ready", {31'd0, cmt_i_ready}, 32'd1);

    // Predicted not taken, resolved taken, compressed; ack in first REQ cycle.
    do_commit(32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 32'h400);
    ack_flush();
    check("fast_turnaround_ready", {31'd0, cmt_i_ready}, 32'd1);

    // fence.i at the top of the address space wraps to 0.
    do_commit(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1, 32'h0);
    ack_flush();
    // fence.i with bjp set: branch rules only, correctly predicted taken.
    do_commit(32'h500, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);

    // Ack while idle is ignored.
    flush_ack = 1'b1;
    @(posedge clk); #1;
    check("idle_ack_ignored", {31'd0, flush_req}, 32'd0);
    flush_ack = 1'b0;

    // Fill the branch counter to saturation with back-to-back commits.
    while (m_bjp < 15)
      do_commit(32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_commit(32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    check("bjp_saturated", {28'd0, bjp_cnt}, 32'hF);
    @(posedge clk); #1;
    do_commit(32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Reset while a flush is pending.
    do_commit(32'h700, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h780, 1'b0, 1'b1, 32'h780);
    @(negedge clk); #1;
    check("pre_rst_flush_req", {31'd0, flush_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_flush_req", {31'd0, flush_req}, 32'd0);
    check("async_rst_ready", {31'd0, cmt_i_ready}, 32'd1);
    check("async_rst_flush_pc", flush_pc, 32'd0);
    check("async_rst_bjp", {28'd0, bjp_cnt}, 32'd0);
    check("async_rst_mis", {28'd0, mis_cnt}, 32'd0);
    m_bjp = 0; m_mis = 0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_commit(32'h800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
